mux_4to1: RTL and testbench
===========================

MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 Parameter: WIDTH, 32, data width of every data input and of out.
REQ-002 Port: CLK  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: RST_N  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: selector  input  3  load-format code choosing the source.
REQ-005 Port: S8  input  WIDTH  sign-extended byte data.
REQ-006 Port: S16  input  WIDTH  sign-extended halfword data.
REQ-007 Port: W  input  WIDTH  full-word data.
REQ-008 Port: U8  input  WIDTH  zero-extended byte data.
REQ-009 Port: U16  input  WIDTH  zero-extended halfword data.
REQ-010 Port: out  output  WIDTH  registered selected data.
REQ-011 Port: err  output  1  registered flag for an unsupported selector code.

Function
REQ-012 Selector decode: 3'd0 selects S8, 3'd1 selects S16, 3'd2 selects W, 3'd4 selects U8, 3'd5 selects U16.
REQ-013 Codes 3'd3, 3'd6 and 3'd7 are invalid: out SHALL load all-zeros and err SHALL load 1.
REQ-014 For a valid code, err SHALL load 0.
REQ-015 out and err SHALL be registered on the rising CLK edge, giving a latency of exactly one cycle from the selector/data sample to the output.
REQ-016 New selector and data values SHALL be accepted every cycle, with no handshake and no stall.
REQ-017 The block SHALL pass the selected input bit-exact, with no extension, truncation or arithmetic; extension is the upstream's responsibility.
REQ-018 A selector change between edges SHALL affect only the next registered value; no glitch on out between edges.
REQ-019 X/unknown bits on non-selected inputs SHALL NOT propagate to out.

Reset
REQ-020 While RST_N = 0, out SHALL be all-zeros and err SHALL be 0, asynchronously, regardless of CLK.
REQ-021 On the first rising CLK edge after RST_N deasserts, the block SHALL register the then-current selector and inputs normally.
REQ-022 Reset asserted mid-stream SHALL discard the pending value; no sample is held across reset.

Structure
REQ-023 Selector code constants SHALL live in a shared package used by both this block and the data-memory load path: SEL_SBYTE=0, SEL_SHALF=1, SEL_WORD=2, SEL_UBYTE=4, SEL_UHALF=5.
REQ-024 The block SHALL be implemented as a combinational decode/select stage followed by one output register stage inside the single module; no sub-module is needed.

Verification
REQ-025 Reset: RST_N=0 with all inputs 32'hFFFFFFFF and selector=2 -> out=0 and err=0 immediately; on release, next edge -> out=32'hFFFFFFFF.
REQ-026 Sweep valid codes with S8=32'hFFFFFF80, S16=32'hFFFF8001, W=32'h12345678, U8=32'h00000080, U16=32'h00008001 -> one cycle after each code 0/1/2/4/5, out equals the matching input and err=0.
REQ-027 Invalid codes 3, 6 and 7 with all inputs nonzero -> next cycle out=0 and err=1; then code 2 -> out=W and err=0.
REQ-028 Latency: selector toggles 0->2 on consecutive edges -> out shows S8 then W, each exactly one cycle later, back-to-back.
REQ-029 Asynchronous reset asserted mid-cycle while out=32'h12345678 -> out=0 without waiting for a CLK edge.

Source files
------------

// File: rtl/mux_4to1_pkg.sv
// Load-format selector codes shared by the load-data mux and the data-memory load path.
// Codes 3, 6 and 7 are unassigned and decode as invalid.
package mux_4to1_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_SBYTE = 3'd0;
    localparam sel_t SEL_SHALF = 3'd1;
    localparam sel_t SEL_WORD  = 3'd2;
    localparam sel_t SEL_UBYTE = 3'd4;
    localparam sel_t SEL_UHALF = 3'd5;

endpackage

// File: rtl/mux_4to1_if.sv
// Selector, pre-extended load data and registered result of the load-data mux.
interface mux_4to1_if #(
    parameter int WIDTH = 32
);
    import mux_4to1_pkg::*;

    sel_t             selector;
    logic [WIDTH-1:0] S8;
    logic [WIDTH-1:0] S16;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] U8;
    logic [WIDTH-1:0] U16;
    logic [WIDTH-1:0] out;
    logic             err;

    modport master (
        output selector, S8, S16, W, U8, U16,
        input  out, err
    );

    modport slave (
        input  selector, S8, S16, W, U8, U16,
        output out, err
    );

endinterface

// File: rtl/mux_4to1.sv
// Load-data mux: picks one pre-extended load word by format code, flags unassigned codes.
// Latency: one cycle, selector/data sampled on rising CLK, out/err registered.
// Backpressure: none; a new selector and data set is accepted every cycle.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    mux_4to1_if.slave    bus
);

    logic [WIDTH-1:0] sel_dat;
    logic             sel_err;
    logic [WIDTH-1:0] out_q;
    logic             err_q;

    // Only the chosen input reaches sel_dat, so unknowns on the others stay out of the register.
    always_comb begin
        sel_dat = '0;
        sel_err = 1'b0;
        case (bus.selector)
            SEL_SBYTE: sel_dat = bus.S8;
            SEL_SHALF: sel_dat = bus.S16;
            SEL_WORD:  sel_dat = bus.W;
            SEL_UBYTE: sel_dat = bus.U8;
            SEL_UHALF: sel_dat = bus.U16;
            default:   sel_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= sel_dat;
            err_q <= sel_err;
        end
    end

    assign bus.out = out_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: expected {out,err} pushed when inputs are driven, popped one edge later.
module tb_mux_4to1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    mux_4to1_if #(.WIDTH(32)) bus ();

    mux_4to1 #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];

    task automatic check_val(input string tag, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out=%h err=%b want out=%h err=%b",
                     tag, act[32:1], act[0], exp[32:1], exp[0]);
        end
    endtask

    // Reference decode written against the code table, independent of the package.
    function automatic logic [32:0] model(input logic [2:0] sel,
                                          input logic [31:0] s8, input logic [31:0] s16,
                                          input logic [31:0] w,  input logic [31:0] u8,
                                          input logic [31:0] u16);
        case (sel)
            3'd0:    return {s8,  1'b0};
            3'd1:    return {s16, 1'b0};
            3'd2:    return {w,   1'b0};
            3'd4:    return {u8,  1'b0};
            3'd5:    return {u16, 1'b0};
            default: return {32'h0, 1'b1};
        endcase
    endfunction

    task automatic set_data(input logic [31:0] s8, input logic [31:0] s16, input logic [31:0] w,
                            input logic [31:0] u8, input logic [31:0] u16);
        bus.S8  = s8;
        bus.S16 = s16;
        bus.W   = w;
        bus.U8  = u8;
        bus.U16 = u16;
    endtask

    // Inputs are already driven; record the expectation, take one edge, compare after it.
    task automatic step(input string tag);
        logic [32:0] e;
        exp_q.push_back(model(bus.selector, bus.S8, bus.S16, bus.W, bus.U8, bus.U16));
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_empty"}, {bus.out, bus.err}, 33'h1_FFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, {bus.out, bus.err}, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] valid_codes[5];
        logic [2:0] bad_codes[3];
        valid_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_codes   = '{3'd3, 3'd6, 3'd7};

        // Reset with everything high: outputs must be zero before any edge.
        bus.selector = 3'd2;
        set_data(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #2;
        check_val("rst_async", {bus.out, bus.err}, 33'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_val("rst_hold", {bus.out, bus.err}, 33'h0);
        RST_N = 1'b1;
        step("rst_release");
        check_val("rst_release_val", {bus.out, bus.err}, {32'hFFFFFFFF, 1'b0});

        // Valid code sweep.
        set_data(32'hFFFFFF80, 32'hFFFF8001, 32'h12345678, 32'h00000080, 32'h00008001);
        foreach (valid_codes[i]) begin
            bus.selector = valid_codes[i];
            step($sformatf("valid_%0d", valid_codes[i]));
        end

        // Invalid codes, then recovery on a valid code.
        foreach (bad_codes[i]) begin
            bus.selector = bad_codes[i];
            step($sformatf("invalid_%0d", bad_codes[i]));
        end
        bus.selector = 3'd2;
        step("recover_word");

        // Back-to-back selector changes each land exactly one edge later.
        bus.selector = 3'd0;
        step("b2b_s8");
        bus.selector = 3'd2;
        step("b2b_w");

        // Unknowns on non-selected inputs must not reach out.
        set_data(32'hFFFFFF80, 32'hxxxxxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx);
        bus.selector = 3'd0;
        step("xiso_s8");
        set_data(32'hxxxxxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx, 32'h00008001);
        bus.selector = 3'd5;
        step("xiso_u16");

        // Reset mid-cycle while out holds a word; the pending sample is dropped.
        set_data(32'h11111111, 32'h22222222, 32'h12345678, 32'h44444444, 32'h55555555);
        bus.selector = 3'd2;
        step("pre_mid_rst");
        bus.selector = 3'd4;
        #2;
        RST_N = 1'b0;
        #1;
        check_val("rst_mid", {bus.out, bus.err}, 33'h0);
        @(posedge CLK);
        #1;
        check_val("rst_mid_hold", {bus.out, bus.err}, 33'h0);
        RST_N = 1'b1;
        bus.selector = 3'd1;
        step("post_rst");

        // Random traffic over all codes.
        for (int n = 0; n < 32; n++) begin
            bus.selector = 3'($urandom_range(0, 7));
            set_data($urandom, $urandom, $urandom, $urandom, $urandom);
            step($sformatf("rand_%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
